// File: rtl/interval_timer.sv
// Interval timer and duration store for the traffic-light controller.
// Holds tBASE/tEXT/tYEL, derives the 1 s tick and runs one countdown at a time.
module interval_timer #(
  parameter int TICKS_PER_SEC = 100_000_000,
  parameter int DEF_BASE      = 6,
  parameter int DEF_EXT       = 3,
  parameter int DEF_YEL       = 2
) (
  input  logic       clk,
  input  logic       Reset_Sync,
  input  logic       Prog_Sync,
  input  logic [1:0] Time_Param_Sel,
  input  logic [3:0] Time_Value,
  input  logic [1:0] interval,
  input  logic       start_timer,
  output logic       expired,
  output logic       busy,
  output logic [4:0] seconds_left,
  output logic       one_sec_tick
);

  localparam int             PW         = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0]  PRESC_LAST = PW'(TICKS_PER_SEC - 1);
  localparam logic [3:0]     D_BASE     = 4'(DEF_BASE);
  localparam logic [3:0]     D_EXT      = 4'(DEF_EXT);
  localparam logic [3:0]     D_YEL      = 4'(DEF_YEL);

  typedef enum logic {IDLE, COUNT} state_t;

  state_t        state_q, state_d;
  logic [3:0]    p_base_q, p_base_d;
  logic [3:0]    p_ext_q, p_ext_d;
  logic [3:0]    p_yel_q, p_yel_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [4:0]    remaining_q, remaining_d;
  logic          expired_q, expired_d;
  logic          tick_q, tick_d;
  logic [4:0]    duration;

  always_ff @(posedge clk) begin
    if (Reset_Sync) begin
      state_q     <= IDLE;
      p_base_q    <= D_BASE;
      p_ext_q     <= D_EXT;
      p_yel_q     <= D_YEL;
      presc_q     <= '0;
      remaining_q <= '0;
      expired_q   <= 1'b0;
      tick_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      p_base_q    <= p_base_d;
      p_ext_q     <= p_ext_d;
      p_yel_q     <= p_yel_d;
      presc_q     <= presc_d;
      remaining_q <= remaining_d;
      expired_q   <= expired_d;
      tick_q      <= tick_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    p_base_d    = p_base_q;
    p_ext_d     = p_ext_q;
    p_yel_d     = p_yel_q;
    presc_d     = presc_q;
    remaining_d = remaining_q;
    expired_d   = 1'b0;
    tick_d      = 1'b0;

    case (interval)
      2'b00:   duration = {1'b0, p_base_q};
      2'b01:   duration = {1'b0, p_ext_q};
      2'b10:   duration = {1'b0, p_yel_q};
      default: duration = {p_base_q, 1'b0};
    endcase

    if (Prog_Sync) begin
      // A zero value restores the default, so no parameter can ever be 0.
      case (Time_Param_Sel)
        2'b00:   p_base_d = (Time_Value == 4'd0) ? D_BASE : Time_Value;
        2'b01:   p_ext_d  = (Time_Value == 4'd0) ? D_EXT  : Time_Value;
        2'b10:   p_yel_d  = (Time_Value == 4'd0) ? D_YEL  : Time_Value;
        default: ;
      endcase
      state_d     = IDLE;
      presc_d     = '0;
      remaining_d = '0;
    end else if (start_timer) begin
      state_d     = COUNT;
      presc_d     = '0;
      remaining_d = duration;
    end else if (state_q == COUNT) begin
      if (presc_q == PRESC_LAST) begin
        presc_d     = '0;
        tick_d      = 1'b1;
        remaining_d = remaining_q - 5'd1;
        if (remaining_q == 5'd1) begin
          state_d   = IDLE;
          expired_d = 1'b1;
        end
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end else begin
      presc_d = '0;
    end
  end

  assign busy         = (state_q == COUNT);
  assign seconds_left = remaining_q;
  assign expired      = expired_q;
  assign one_sec_tick = tick_q;

endmodule

// File: doc/interval_timer.md
# interval_timer

Programmable interval timer and time-parameter store for the traffic-light controller. It holds the three programmable durations (tBASE, tEXT, tYEL), derives the 1 s time base from the system clock, and runs the countdown requested by the light-sequencing FSM through `interval` and `start_timer`. It returns a one-cycle `expired` pulse when the countdown ends. Programming requests arrive already synchronised and are applied between light phases, so a new duration takes effect on the next `start_timer`.

## Interface
- `TICKS_PER_SEC`, 100_000_000: clock cycles per 1 s tick; the bench sets 4.
- `DEF_BASE`, 6: reset/default tBASE in seconds (4-bit).
- `DEF_EXT`, 3: reset/default tEXT in seconds (4-bit).
- `DEF_YEL`, 2: reset/default tYEL in seconds (4-bit).
- `clk` in 1: single system clock; all logic is on posedge.
- `Reset_Sync` in 1: synchronous, active-high reset.
- `Prog_Sync` in 1: one-cycle program strobe.
- `Time_Param_Sel` in 2: program target. 00 = tBASE, 01 = tEXT, 10 = tYEL, 11 = no write.
- `Time_Value` in 4: new value in seconds; 0 means restore the default for the selected parameter.
- `interval` in 2: duration select. 00 = tBASE, 01 = tEXT, 10 = tYEL, 11 = 2·tBASE.
- `start_timer` in 1: load and start the countdown.
- `expired` out 1: one-cycle pulse at the end of the countdown.
- `busy` out 1: high while counting.
- `seconds_left` out 5: remaining whole seconds, for display.
- `one_sec_tick` out 1: one-cycle pulse per elapsed second while busy.

## Operation
- **Registers:**
  - `p_base`, `p_ext`, `p_yel`: 4-bit parameter registers.
  - `presc`: prescaler, ceil(log2(TICKS_PER_SEC)) bits.
  - `remaining`: 5-bit countdown.
  - State: IDLE or COUNT.
- **Priority, per cycle (highest first):** `Reset_Sync`, then `Prog_Sync`, then `start_timer`, then tick/decrement.
- **Reset:**
  - Parameters return to their defaults.
  - `presc`=0, `remaining`=0, state=IDLE.
  - All outputs are 0.
- **Program (`Prog_Sync`=1):**
  - If `Time_Param_Sel`≠11, the selected register gets `Time_Value`, or the default if `Time_Value`=0. Sel=11 writes nothing.
  - Independent of the write, the active count is aborted: state=IDLE, `remaining`=0, `presc`=0, and no `expired` is produced.
  - A `start_timer` in the same cycle is ignored.
- **Load (`start_timer`=1, no reset/program):**
  - `remaining` ← duration(`interval`). 2·tBASE is `{p_base,1'b0}` (5-bit, max 30). The other durations are zero-extended to 5 bits.
  - `presc` ← 0, state ← COUNT.
  - A load is legal from IDLE or COUNT. In COUNT it restarts the countdown and cancels any pending expiry.
- **COUNT:**
  - `presc` increments every cycle.
  - When `presc`=TICKS_PER_SEC−1: `presc`←0, `one_sec_tick`=1 next cycle, and `remaining` decrements.
  - When the decrement takes `remaining` from 1 to 0: state←IDLE and `expired`=1 for exactly the next cycle.
- **IDLE:**
  - `presc` is held at 0, with no ticks and no expiry.
  - A new `start_timer` while `expired` is high is accepted normally.
- **Zero duration:** cannot occur, because parameter registers are never 0.
- `busy` = (state==COUNT). `seconds_left` = `remaining`.

## Timing
- Let edge E0 be the edge that samples `start_timer`=1 with duration D seconds and N=TICKS_PER_SEC.
  - `busy` is high from E0+1 through E0+D·N.
  - `seconds_left` shows D after E0, and D−k after edge E0+k·N.
  - `one_sec_tick` is high in the cycle after each edge E0+k·N, for k=1..D.
  - `expired` is high in the single cycle between E0+D·N and E0+D·N+1, coincident with the final `one_sec_tick`.
- **FSM handshake:** the FSM registers `start_timer` on the edge that samples `expired`. The next `start_timer` therefore arrives one cycle after `expired` and is accepted; the idle gap is one cycle.
- **Programming latency:** a parameter written at edge Ep is used by any load sampled at Ep+1 or later. This covers the FSM's restart, which it issues on the cycle after `Prog_Sync`.
- **Reset mid-count:** all outputs are 0 from the following cycle, and an `expired` due in that cycle is suppressed.

## Test plan
- **Defaults:** reset, then `start_timer` with `interval`=10, N=4 -> `expired` exactly 8 cycles after the load edge; `seconds_left` goes 2,1,0; two `one_sec_tick` pulses.
- **Doubled base:** `interval`=11 after reset -> `seconds_left` loads 12 and `expired` comes at +48. Then program tBASE=15 -> `seconds_left` loads 30 and `expired` comes at +120.
- **Program rules:**
  - Program tEXT=5 -> a tEXT load expires at +20.
  - Program tEXT=0 -> reverts to 3, expiry at +12.
  - Sel=11 with value 9 -> no register changes.
- **Restart:** load tYEL, then assert `start_timer` again at +5 with tEXT -> no `expired` at +8; `expired` at +5+12.
- **Abort:** `Prog_Sync` at +3 of a count with `start_timer` held high in the same cycle -> `busy`=0 the next cycle, no `expired`, and `start_timer` ignored.
- **Reset mid-count:** `Reset_Sync` on the edge where expiry is due -> no `expired` pulse, and all parameters are back to 6/3/2.
